sad_search_engine: RTL and testbench
====================================

SAD_SEARCH_ENGINE -- requirements
Module: sad_search_engine

Interface
REQ-001 SHALL have parameter PIXEL, default 8, bits per pixel.
REQ-002 SHALL have parameter BLK, default 8, pixels per block row and rows per block (BLK power of two, 4..32).
REQ-003 SHALL have parameter NUM_CAND, default 16, candidate positions per search (2..1024).
REQ-004 SHALL derive SAD_W = PIXEL + log2(BLK*BLK) and CAND_W = ceil(log2(NUM_CAND)).
REQ-005 clk  input  1  rising-edge clock; one clock domain; reset is synchronous and active-high.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle pulse to begin a search; honoured only in IDLE.
REQ-008 cur_row  input  BLK*PIXEL  current-block row; pixel k at bits [k*PIXEL +: PIXEL].
REQ-009 ref_row  input  BLK*PIXEL  reference row for the active candidate, same packing.
REQ-010 row_valid  input  1  cur_row/ref_row valid this cycle.
REQ-011 row_ready  output  1  engine accepts a row this cycle.
REQ-012 cand_sad  output  SAD_W  SAD of the candidate just completed.
REQ-013 cand_sad_valid  output  1  one-cycle pulse qualifying cand_sad.
REQ-014 best_sad  output  SAD_W  minimum SAD found so far in the current search.
REQ-015 best_idx  output  CAND_W  candidate index of best_sad.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse when the search completes.

Function
REQ-018 The FSM SHALL have states IDLE, ACCUM and FINISH.
REQ-019 IDLE->ACCUM on start; the row counter, candidate counter and accumulator clear, best_sad loads all-ones and best_idx loads 0.
REQ-020 row_ready SHALL be high exactly in ACCUM; a row is accepted when row_valid and row_ready are both high.
REQ-021 The row SAD SHALL be the unsigned sum over k of |cur_k - ref_k|, computed at full width with no truncation and no saturation.
REQ-022 On each accepted row the accumulator SHALL add the row SAD and the row counter SHALL increment; cycles with row_valid low leave all state unchanged.
REQ-023 On the accepted row BLK-1: cand_sad SHALL equal the accumulator plus that row SAD, cand_sad_valid SHALL pulse the following cycle, the accumulator and row counter SHALL clear, and the candidate counter SHALL increment.
REQ-024 The next candidate's first row SHALL be acceptable in the cycle immediately after its predecessor's last row (zero bubble).
REQ-025 best_sad/best_idx SHALL update in the same cycle cand_sad_valid rises, iff cand_sad < best_sad (strict); a tie keeps the earlier index.
REQ-026 After candidate NUM_CAND-1 completes, the FSM SHALL enter FINISH, pulse done for one cycle with final best_sad/best_idx valid, and return to IDLE.
REQ-027 best_sad/best_idx SHALL hold their values in IDLE until the next accepted start.
REQ-028 start while busy SHALL be ignored; row_valid in IDLE or FINISH SHALL be ignored.
REQ-029 Latency SHALL be NUM_CAND*BLK accepted rows plus 2 cycles from the first accepted row to done.

Reset
REQ-030 rst SHALL force IDLE and clear all counters and the accumulator, with row_ready=0, busy=0, done=0, cand_sad_valid=0, cand_sad=0, best_sad=all-ones and best_idx=0.
REQ-031 rst asserted mid-search SHALL abort the search without a done pulse; rst takes priority over start and row_valid in the same cycle.

Structure
REQ-032 PIXEL, the default BLK/NUM_CAND values and the SAD_W/CAND_W width functions SHALL live in the shared package me_pkg.
REQ-033 The absolute-difference adder tree SHALL be the combinational sub-module sad_row_tree (parameters PIXEL, BLK; output width PIXEL+log2(BLK)).
REQ-034 The implementation SHALL NOT contain a register stage inside sad_row_tree; all state SHALL live in sad_search_engine.

Verification
REQ-035 Uniform data: default params, all cur pixels 8'h33 and ref pixels 8'h55 for every candidate -> each cand_sad = 2176 (0x880), best_sad = 2176, best_idx = 0 (tie rule).
REQ-036 Minimum tracking: candidate 5 has ref = cur, all others as in REQ-035 -> cand_sad for candidate 5 = 0; final best_sad = 0, best_idx = 5; done asserts once.
REQ-037 Maximum value: cur 8'hFF, ref 8'h00 -> cand_sad = 16320, no overflow in SAD_W = 14 bits.
REQ-038 Backpressure and gaps: row_valid toggled randomly -> identical results to REQ-036; done arrives after exactly 128 accepted rows + 2 cycles.
REQ-039 Reset and start abuse: rst asserted after 3 candidates, then a fresh search -> no stale best_sad; a start pulse mid-search is ignored, and a 1-cycle rst mid-row leaves all outputs at their reset values.

Source files
------------

// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared parameters, width functions and FSM encoding for the SAD search engine
package me_pkg;

    localparam int ME_PIXEL    = 8;
    localparam int ME_BLK      = 8;
    localparam int ME_NUM_CAND = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2
    } sad_state_e;

    function automatic int sad_w(input int pixel, input int blk);
        return pixel + $clog2(blk * blk);
    endfunction

    function automatic int row_sad_w(input int pixel, input int blk);
        return pixel + $clog2(blk);
    endfunction

    function automatic int cand_w(input int num_cand);
        return (num_cand > 1) ? $clog2(num_cand) : 1;
    endfunction

endpackage

// File: rtl/sad_row_tree.sv
// rtl/sad_row_tree.sv - combinational sum of absolute pixel differences across one block row
module sad_row_tree
    import me_pkg::*;
#(
    parameter int  PIXEL = ME_PIXEL,
    parameter int  BLK   = ME_BLK,
    localparam int OUT_W = row_sad_w(PIXEL, BLK)
) (
    input  logic [BLK*PIXEL-1:0] cur_row,
    input  logic [BLK*PIXEL-1:0] ref_row,
    output logic [OUT_W-1:0]     row_sad
);

    function automatic logic [PIXEL-1:0] abs_diff(input logic [PIXEL-1:0] x,
                                                  input logic [PIXEL-1:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

    // OUT_W holds BLK * (2**PIXEL - 1) exactly, so the running sum never wraps
    always_comb begin
        row_sad = '0;
        for (int k = 0; k < BLK; k++) begin
            row_sad = row_sad + OUT_W'(abs_diff(cur_row[k*PIXEL +: PIXEL],
                                                ref_row[k*PIXEL +: PIXEL]));
        end
    end

endmodule

// File: rtl/sad_search_engine.sv
// rtl/sad_search_engine.sv - block-matching search: accumulates per-candidate SAD and tracks the minimum
module sad_search_engine
    import me_pkg::*;
#(
    parameter int  PIXEL    = ME_PIXEL,
    parameter int  BLK      = ME_BLK,
    parameter int  NUM_CAND = ME_NUM_CAND,
    localparam int SAD_W    = sad_w(PIXEL, BLK),
    localparam int CAND_W   = cand_w(NUM_CAND)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BLK*PIXEL-1:0] cur_row,
    input  logic [BLK*PIXEL-1:0] ref_row,
    input  logic                 row_valid,
    output logic                 row_ready,
    output logic [SAD_W-1:0]     cand_sad,
    output logic                 cand_sad_valid,
    output logic [SAD_W-1:0]     best_sad,
    output logic [CAND_W-1:0]    best_idx,
    output logic                 busy,
    output logic                 done
);

    localparam int ROW_W     = $clog2(BLK);
    localparam int ROW_SAD_W = row_sad_w(PIXEL, BLK);

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(BLK - 1);
    localparam logic [CAND_W-1:0] LAST_CAND = CAND_W'(NUM_CAND - 1);

    sad_state_e          state_q, state_d;
    logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
    logic [CAND_W-1:0]   cand_cnt_q, cand_cnt_d;
    logic [SAD_W-1:0]    acc_q, acc_d;
    logic [SAD_W-1:0]    cand_sad_q, cand_sad_d;
    logic                cand_valid_q, cand_valid_d;
    logic [SAD_W-1:0]    best_sad_q, best_sad_d;
    logic [CAND_W-1:0]   best_idx_q, best_idx_d;
    logic                done_q, done_d;

    logic [ROW_SAD_W-1:0] row_sad;
    logic [SAD_W-1:0]     cand_sum;
    logic                 row_accept;
    logic                 last_row;
    logic                 last_cand;

    sad_row_tree #(
        .PIXEL (PIXEL),
        .BLK   (BLK)
    ) u_row_tree (
        .cur_row (cur_row),
        .ref_row (ref_row),
        .row_sad (row_sad)
    );

    assign row_accept = row_valid & row_ready;
    assign last_row   = (row_cnt_q == LAST_ROW);
    assign last_cand  = (cand_cnt_q == LAST_CAND);
    assign cand_sum   = acc_q + SAD_W'(row_sad);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_cnt_q    <= '0;
            cand_cnt_q   <= '0;
            acc_q        <= '0;
            cand_sad_q   <= '0;
            cand_valid_q <= 1'b0;
            best_sad_q   <= '1;
            best_idx_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            cand_cnt_q   <= cand_cnt_d;
            acc_q        <= acc_d;
            cand_sad_q   <= cand_sad_d;
            cand_valid_q <= cand_valid_d;
            best_sad_q   <= best_sad_d;
            best_idx_q   <= best_idx_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_ACCUM;
            ST_ACCUM:  if (row_accept && last_row && last_cand) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Comparison uses the freshly summed candidate so best_* moves on the same edge as cand_sad_valid
    always_comb begin
        row_cnt_d    = row_cnt_q;
        cand_cnt_d   = cand_cnt_q;
        acc_d        = acc_q;
        cand_sad_d   = cand_sad_q;
        cand_valid_d = 1'b0;
        best_sad_d   = best_sad_q;
        best_idx_d   = best_idx_q;
        if (state_q == ST_IDLE && start) begin
            row_cnt_d  = '0;
            cand_cnt_d = '0;
            acc_d      = '0;
            best_sad_d = '1;
            best_idx_d = '0;
        end else if (row_accept) begin
            if (last_row) begin
                cand_sad_d   = cand_sum;
                cand_valid_d = 1'b1;
                acc_d        = '0;
                row_cnt_d    = '0;
                cand_cnt_d   = cand_cnt_q + CAND_W'(1);
                if (cand_sum < best_sad_q) begin
                    best_sad_d = cand_sum;
                    best_idx_d = cand_cnt_q;
                end
            end else begin
                acc_d     = cand_sum;
                row_cnt_d = row_cnt_q + ROW_W'(1);
            end
        end
    end

    always_comb begin
        row_ready = 1'b0;
        busy      = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                row_ready = 1'b1;
                busy      = 1'b1;
            end
            ST_FINISH: begin
                busy   = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign cand_sad       = cand_sad_q;
    assign cand_sad_valid = cand_valid_q;
    assign best_sad       = best_sad_q;
    assign best_idx       = best_idx_q;
    assign done           = done_q;

endmodule

// File: tb/tb_sad_search_engine.sv
// tb/tb_sad_search_engine.sv - scoreboard bench for sad_search_engine at default parameters
module tb_sad_search_engine;

    localparam int PIXEL  = 8;
    localparam int BLK    = 8;
    localparam int NC     = 16;
    localparam int SAD_W  = 14;
    localparam int CAND_W = 4;

    typedef struct {
        logic [SAD_W-1:0]  sad;
        logic [SAD_W-1:0]  best;
        logic [CAND_W-1:0] idx;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [BLK*PIXEL-1:0] cur_row = '0;
    logic [BLK*PIXEL-1:0] ref_row = '0;
    logic                 row_valid = 1'b0;
    logic                 row_ready;
    logic [SAD_W-1:0]     cand_sad;
    logic                 cand_sad_valid;
    logic [SAD_W-1:0]     best_sad;
    logic [CAND_W-1:0]    best_idx;
    logic                 busy;
    logic                 done;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];

    sad_search_engine #(
        .PIXEL    (PIXEL),
        .BLK      (BLK),
        .NUM_CAND (NC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cur_row        (cur_row),
        .ref_row        (ref_row),
        .row_valid      (row_valid),
        .row_ready      (row_ready),
        .cand_sad       (cand_sad),
        .cand_sad_valid (cand_sad_valid),
        .best_sad       (best_sad),
        .best_idx       (best_idx),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors + 1);
        $fatal(1);
    end

    // Mode 0 uniform, 1/4 candidate 5/1 matches, 2 max contrast, 3 hashed texture
    function automatic logic [7:0] pix(input int mode, input int c, input int r, input int k, input bit is_ref);
        int unsigned h;
        case (mode)
            0: return is_ref ? 8'h55 : 8'h33;
            1: return (is_ref && c != 5) ? 8'h55 : 8'h33;
            4: return (is_ref && c != 1) ? 8'h55 : 8'h33;
            2: return is_ref ? 8'h00 : 8'hFF;
            default: begin
                h = (c * 131 + r * 29 + k * 7 + (is_ref ? 97 : 0)) * 40503 + 12345;
                return h[15:8];
            end
        endcase
    endfunction

    function automatic int cand_sad_ref(input int mode, input int c);
        int s, a, b;
        s = 0;
        for (int r = 0; r < BLK; r++)
            for (int k = 0; k < BLK; k++) begin
                a = int'(pix(mode, c, r, k, 1'b0));
                b = int'(pix(mode, c, r, k, 1'b1));
                s += (a > b) ? (a - b) : (b - a);
            end
        return s;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) done_cnt++;
        if (cand_sad_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow cand_sad %0d with no expected entry", cand_sad);
            end else begin
                e = exp_q.pop_front();
                if (cand_sad !== e.sad) begin
                    errors++;
                    $display("FAIL sb_cand_sad got %0d exp %0d", cand_sad, e.sad);
                end
                checks++;
                if (best_sad !== e.best || best_idx !== e.idx) begin
                    errors++;
                    $display("FAIL sb_best got %0d/%0d exp %0d/%0d", best_sad, best_idx, e.best, e.idx);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (row_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cand_sad_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_ctrl got rdy%b busy%b done%b val%b exp all 0", tag, row_ready, busy, done, cand_sad_valid);
        end
        checks++;
        if (cand_sad !== '0) begin
            errors++;
            $display("FAIL %s_cand_sad got %0d exp 0", tag, cand_sad);
        end
        checks++;
        if (best_sad !== {SAD_W{1'b1}} || best_idx !== '0) begin
            errors++;
            $display("FAIL %s_best got %0d/%0d exp 16383/0", tag, best_sad, best_idx);
        end
    endtask

    task automatic run_search(input int mode, input bit gaps, input int abort_rows,
                              input bit start_abuse, input string tag);
        int c, r, acc_rows, guard, last_cyc, done_cyc, done_before, sad;
        bit acc, pushed;
        exp_t e;
        logic [SAD_W-1:0]  mbest;
        logic [CAND_W-1:0] midx;
        mbest = '1; midx = '0;
        c = 0; r = 0; acc_rows = 0; guard = 0; pushed = 0; last_cyc = 0;
        done_before = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (c < NC && guard < 4000 && !(abort_rows > 0 && acc_rows >= abort_rows)) begin
            if (!pushed) begin
                sad = cand_sad_ref(mode, c);
                if (SAD_W'(sad) < mbest) begin
                    mbest = SAD_W'(sad);
                    midx  = CAND_W'(c);
                end
                e.sad = SAD_W'(sad); e.best = mbest; e.idx = midx;
                exp_q.push_back(e);
                pushed = 1'b1;
            end
            for (int k = 0; k < BLK; k++) begin
                cur_row[k*PIXEL +: PIXEL] = pix(mode, c, r, k, 1'b0);
                ref_row[k*PIXEL +: PIXEL] = pix(mode, c, r, k, 1'b1);
            end
            row_valid = !(gaps && $urandom_range(0, 2) == 0);
            start = start_abuse && c == 8 && r == 3;
            @(negedge clk);
            acc = row_valid && row_ready;
            if (acc) last_cyc = cyc;
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
            if (acc) begin
                acc_rows++;
                r++;
                if (r == BLK) begin
                    r = 0; c++; pushed = 1'b0;
                end
            end
        end
        checks++;
        if (guard >= 4000) begin
            errors++;
            $display("FAIL %s_row_timeout accepted %0d rows", tag, acc_rows);
        end
        if (abort_rows > 0) begin
            rst = 1'b1; start = 1'b1; row_valid = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0; start = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check_reset_outputs(tag);
            row_valid = 1'b0;
            exp_q.delete();
            checks++;
            if (done_cnt != done_before) begin
                errors++;
                $display("FAIL %s_abort_done got %0d pulses exp 0", tag, done_cnt - done_before);
            end
            return;
        end
        row_valid = 1'b0;
        guard = 0; done_cyc = -1;
        while (guard < 20) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (done_cyc < 0 || done_cyc - last_cyc != 2 || acc_rows != NC * BLK) begin
            errors++;
            $display("FAIL %s_latency got rows %0d done-last %0d exp rows %0d done-last 2",
                     tag, acc_rows, done_cyc - last_cyc, NC * BLK);
        end
        checks++;
        if (best_sad !== mbest || best_idx !== midx) begin
            errors++;
            $display("FAIL %s_final_best got %0d/%0d exp %0d/%0d", tag, best_sad, best_idx, mbest, midx);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 row_valid = (i % 2 == 0);
        end
        @(negedge clk);
        row_valid = 1'b0;
        checks++;
        if (best_sad !== mbest || best_idx !== midx || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_hold got %0d/%0d busy %b exp %0d/%0d busy 0", tag, best_sad, best_idx, busy, mbest, midx);
        end
        checks++;
        if (done_cnt - done_before != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_done_once got %0d pulses %0d pending exp 1 pulse 0 pending",
                     tag, done_cnt - done_before, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        #1 rst = 1'b0;
    endtask

    task automatic test_uniform;
        run_search(0, 1'b0, 0, 1'b0, "uniform");
    endtask

    task automatic test_min_tracking;
        run_search(1, 1'b0, 0, 1'b0, "min_track");
    endtask

    task automatic test_max_value;
        run_search(2, 1'b0, 0, 1'b0, "max_value");
    endtask

    task automatic test_back_to_back;
        run_search(3, 1'b0, 0, 1'b0, "pattern_a");
        run_search(3, 1'b1, 0, 1'b0, "pattern_b");
    endtask

    task automatic test_backpressure;
        run_search(1, 1'b1, 0, 1'b0, "backpressure");
    endtask

    task automatic test_reset_abuse;
        run_search(4, 1'b0, 3 * BLK, 1'b0, "abort3");
        run_search(0, 1'b0, 0, 1'b1, "fresh");
        run_search(0, 1'b1, BLK + 2, 1'b0, "midrow");
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_min_tracking();
        test_max_value();
        test_back_to_back();
        test_backpressure();
        test_reset_abuse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
